keypad_label_scanner: RTL and testbench

//   Drives the shuffled keypad labels out to a 10-position 7-segment display, scanning one position at a time.
//   It is the output-side counterpart of the button-index path: the lock maps a button index to a digit,
//   and this block shows the user which digit each button currently means.
//   A new index->digit map is double-buffered and swapped in only at a frame boundary, so the display never tears.

---
 rtl/keypad_label_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_label_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/keypad_label_scanner.sv
// keypad_label_scanner: multiplexes the current button->digit labels onto a
// NUM_POS-position common-anode 7-segment display, one position per dwell.
// A new map is staged and swapped into the shadow copy only at a frame
// boundary so a frame is never drawn with two different maps.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   map_i        packed map, digit for button i in map_i[4i+3:4i]
//   map_load_i   1-cycle request to capture map_i as the next map
//   blank_i      forces the display dark; scanning continues
//   map_ack_o    1-cycle pulse when a pending map becomes visible
//   frame_o      1-cycle pulse at the start of each frame
//   an_o         one-hot active-low position select
//   seg_o        active-low segments {g,f,e,d,c,b,a}
module keypad_label_scanner #(
    parameter int unsigned NUM_POS = 10,
    parameter int unsigned DIV     = 1000,
    parameter int unsigned BLANK   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_POS-1:0]   map_i,
    input  logic                   map_load_i,
    input  logic                   blank_i,
    output logic                   map_ack_o,
    output logic                   frame_o,
    output logic [NUM_POS-1:0]     an_o,
    output logic [6:0]             seg_o
);

    localparam int unsigned TICK_W = $clog2(DIV);
    localparam int unsigned POS_W  = $clog2(NUM_POS);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [3:0]          staging_q [NUM_POS];
    logic [3:0]          staging_d [NUM_POS];
    logic [3:0]          shadow_q  [NUM_POS];
    logic [3:0]          shadow_d  [NUM_POS];
    logic [3:0]          map_arr   [NUM_POS];
    logic                ack_d, frame_d;
    logic [NUM_POS-1:0]  an_d;
    logic [6:0]          seg_d;
    logic                tick_wrap_c;
    logic                boundary_c;

    // Active-low digit decode; anything above 9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Unpack the flat map input into per-position nibbles.
    always_comb begin
        for (int i = 0; i < int'(NUM_POS); i++) begin
            map_arr[i] = map_i[4*i +: 4];
        end
    end

    assign tick_wrap_c = (tick_q == TICK_W'(DIV - 1));
    assign boundary_c  = tick_wrap_c && (pos_q == POS_W'(NUM_POS - 1));

    // Next-state: scan counters, map FSM and registered display outputs.
    always_comb begin
        tick_d    = tick_q + TICK_W'(1);
        pos_d     = pos_q;
        state_d   = state_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        ack_d     = 1'b0;
        frame_d   = boundary_c;
        an_d      = '1;
        seg_d     = 7'h7F;

        if (tick_wrap_c) begin
            tick_d = '0;
            pos_d  = (pos_q == POS_W'(NUM_POS - 1)) ? '0 : pos_q + POS_W'(1);
        end

        if (boundary_c) begin
            // A load landing on the boundary itself skips staging.
            if (map_load_i) begin
                shadow_d = map_arr;
                ack_d    = 1'b1;
            end else if (state_q == PEND) begin
                shadow_d = staging_q;
                ack_d    = 1'b1;
            end
            state_d = IDLE;
        end else if (map_load_i) begin
            staging_d = map_arr;
            state_d   = PEND;
        end

        // Leading BLANK cycles of each dwell stay dark to hide ghosting.
        if ((tick_q >= TICK_W'(BLANK)) && !blank_i) begin
            an_d[pos_q] = 1'b0;
            seg_d       = decode(shadow_q[pos_q]);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            pos_q     <= '0;
            map_ack_o <= 1'b0;
            frame_o   <= 1'b0;
            an_o      <= '1;
            seg_o     <= 7'h7F;
            for (int i = 0; i < int'(NUM_POS); i++) begin
                staging_q[i] <= 4'(i);
                shadow_q[i]  <= 4'(i);
            end
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            pos_q     <= pos_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            map_ack_o <= ack_d;
            frame_o   <= frame_d;
            an_o      <= an_d;
            seg_o     <= seg_d;
        end
    end

endmodule

// File: tb/tb_keypad_label_scanner.sv
// Directed bench for keypad_label_scanner with DIV=8, BLANK=2, NUM_POS=10.
// n counts clock edges since the last reset edge; outputs seen after edge n
// reflect counter state n-1, so tick=(n-1)%8 and pos=((n-1)/8)%10.
module tb_keypad_label_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] map_i;
    logic        map_load_i;
    logic        blank_i;
    logic        map_ack_o;
    logic        frame_o;
    logic [9:0]  an_o;
    logic [6:0]  seg_o;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int frames = 0;
    int acks   = 0;

    keypad_label_scanner #(
        .NUM_POS(10),
        .DIV    (8),
        .BLANK  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .map_i     (map_i),
        .map_load_i(map_load_i),
        .blank_i   (blank_i),
        .map_ack_o (map_ack_o),
        .frame_o   (frame_o),
        .an_o      (an_o),
        .seg_o     (seg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (frame_o)   frames++;
        if (map_ack_o) acks++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    // Hold load for exactly one sampling edge.
    task automatic load(input logic [39:0] m);
        map_i      = m;
        map_load_i = 1'b1;
        step();
        map_load_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0; frames = 0; acks = 0;
    endtask

    initial begin
        rst = 1'b1; map_i = 40'h9876543210; map_load_i = 1'b0; blank_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: reset values then first lit position
        chk("rst_an", 32'(an_o), 32'h3FF);
        chk("rst_seg", 32'(seg_o), 32'h7F);
        chk("rst_ack", 32'(map_ack_o), 32'h0);
        chk("rst_frame", 32'(frame_o), 32'h0);
        step(); chk("c1_an", 32'(an_o), 32'h3FF);
        step(); chk("c2_an", 32'(an_o), 32'h3FF);
        step();
        chk("c3_an", 32'(an_o), 32'h3FE);
        chk("c3_seg", 32'(seg_o), 32'h40);

        // 2: last position and frame pulse
        run_to(75);
        chk("pos9_an", 32'(an_o), 32'h1FF);
        chk("pos9_seg", 32'(seg_o), 32'h10);
        run_to(79); chk("frame_pre", 32'(frame_o), 32'h0);
        step();     chk("frame_80", 32'(frame_o), 32'h1);
        step();     chk("frame_post", 32'(frame_o), 32'h0);
        chk("frame_cnt", 32'(frames), 32'd1);
        chk("noack_idle", 32'(acks), 32'd0);

        // 3: single load mid-frame, shown after the boundary
        run_to(100);
        load(40'h9876543217);
        run_to(103);
        chk("pend_an", 32'(an_o), 32'h3FB);
        chk("pend_seg", 32'(seg_o), 32'h24);
        run_to(159); chk("ack_pre", 32'(map_ack_o), 32'h0);
        step();
        chk("ack_160", 32'(map_ack_o), 32'h1);
        chk("frame_160", 32'(frame_o), 32'h1);
        step(); chk("ack_post", 32'(map_ack_o), 32'h0);
        run_to(163);
        chk("new0_an", 32'(an_o), 32'h3FE);
        chk("new0_seg", 32'(seg_o), 32'h78);

        // 4: two loads in one frame give one ack, latest map wins
        run_to(170); load(40'h9876543213);
        run_to(200); load(40'h9876543215);
        run_to(239); chk("ack2_pre", 32'(map_ack_o), 32'h0);
        step();      chk("ack2_240", 32'(map_ack_o), 32'h1);
        run_to(243);
        chk("ack2_cnt", 32'(acks), 32'd2);
        chk("latest_seg", 32'(seg_o), 32'h12);

        // 5: dash for out-of-range digit, then blanking
        run_to(250); load(40'h9876543C15);
        run_to(320); chk("ack3_320", 32'(map_ack_o), 32'h1);
        run_to(340);
        chk("dash_an", 32'(an_o), 32'h3FB);
        chk("dash_seg", 32'(seg_o), 32'h3F);
        blank_i = 1'b1;
        step();
        chk("blank_an", 32'(an_o), 32'h3FF);
        chk("blank_seg", 32'(seg_o), 32'h7F);
        run_to(350); load(40'h9876543210);
        run_to(399); chk("ackb_pre", 32'(map_ack_o), 32'h0);
        step();
        chk("ackb_400", 32'(map_ack_o), 32'h1);
        chk("ackb_an", 32'(an_o), 32'h3FF);
        blank_i = 1'b0;
        run_to(403);
        chk("unblank_an", 32'(an_o), 32'h3FE);
        chk("unblank_seg", 32'(seg_o), 32'h40);

        // 6: reset while pending discards the map and the ack
        run_to(410); load(40'h9876543218);
        run_to(420);
        do_reset();
        chk("rst2_an", 32'(an_o), 32'h3FF);
        chk("rst2_seg", 32'(seg_o), 32'h7F);
        chk("rst2_ack", 32'(map_ack_o), 32'h0);
        run_to(3);
        chk("rst2_id_seg", 32'(seg_o), 32'h40);
        run_to(83);
        chk("rst2_noack", 32'(acks), 32'd0);
        chk("rst2_frames", 32'(frames), 32'd1);
        run_to(88);
        chk("rst2_id_seg2", 32'(seg_o), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
